sha256_nonce_dispatcher: RTL and testbench
==========================================

# sha256_nonce_dispatcher

Feeds the unrolled SHA-256 hashing pipeline and consumes its results. Loads one job (midstate, 96-bit block tail, nonce range), issues one padded 512-bit data block with a fresh nonce every clock, and tracks in-flight nonces through a fixed-latency valid pipeline. It aligns the returned hash word with its nonce and queues winning ("golden") nonces in a small FIFO with a valid/ready handshake.

## Interface
- `LATENCY`, 8: clocks from a nonce appearing on `tx_data` to its hash word appearing on `rx_hash`; ≥1; top level overrides.
- `NONCE_STRIDE`, 1: nonce increment per issue, for partitioning across cores.
- `FIFO_DEPTH`, 4: golden FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_work_valid` in 1: one-cycle strobe that loads a job.
- `rx_work_midstate` in 256: midstate captured on load.
- `rx_work_data` in 96: block words 0..2 captured on load.
- `rx_work_nonce` in 32: first nonce.
- `rx_work_count` in 32: nonces to scan; 0 means 2^32.
- `tx_state` out 256: registered midstate to the hasher.
- `tx_data` out 512: data block to the hasher.
- `rx_hash` in 32: result word from the hasher; zero means golden.
- `tx_golden_valid` out 1: FIFO not empty.
- `tx_golden_nonce` out 32: FIFO head.
- `rx_golden_ready` in 1: pop when high together with valid.
- `tx_busy` out 1: state ≠ IDLE.
- `tx_overflow` out 1: sticky; a golden was dropped.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `rx_work_valid`.
  - RUN → DRAIN after the last of `count` nonces is issued.
  - DRAIN → IDLE when the in-flight valid pipeline is all zero.
  - `rx_work_valid` in any state loads the job and enters RUN (abort and restart).
- Load behaviour: capture midstate and data; `issue_nonce` = `check_nonce` = `rx_work_nonce`; `remaining` = count.
  - The in-flight valid pipeline is cleared on load, so results of the previous job still in the hasher are dropped.
  - The golden FIFO is not flushed on load.
- `tx_data` layout, 32-bit words where word x is bits [32x+31:32x]:
  - words 0..2 = `rx_work_data`
  - word 3 = current nonce
  - word 4 = 32'h80000000
  - words 5..14 = 0
  - word 15 = 32'h00000280
- RUN, each cycle:
  - Present `issue_nonce`.
  - Shift a 1 into the LATENCY-deep valid pipeline.
  - `issue_nonce` += `NONCE_STRIDE` (mod 2^32; wrap is legal).
  - Decrement `remaining`.
  - In DRAIN and IDLE, shift in 0. `tx_data` holds its last value.
- Check, each cycle the pipeline output bit is 1:
  - If `rx_hash` == 0, push `check_nonce` into the FIFO.
  - Then `check_nonce` += `NONCE_STRIDE`.
- FIFO push rules:
  - Full and no pop in the same cycle: the push is dropped and `tx_overflow` is set.
  - Full with a pop in the same cycle: the push is accepted.
  - `tx_overflow` clears only on reset.
- All nonce arithmetic is 32-bit modulo.

## Timing
- Reset values: `tx_state` = 0, `tx_data` = 0, `tx_golden_valid` = 0, `tx_golden_nonce` = 0, `tx_busy` = 0, `tx_overflow` = 0. FIFO is empty, pipeline is zero, state is IDLE.
- Load sampled at edge T:
  - `tx_state` valid from T+1.
  - Nonce k (k = 0..count−1) is on `tx_data` during cycle T+1+k.
  - Its hash is sampled at edge T+1+k+LATENCY.
- Golden latency: hash sampled at edge E → `tx_golden_valid` = 1 and nonce on the head from E+1 (when the FIFO was empty).
- `tx_busy`:
  - high from T+1;
  - low from T+count+LATENCY+1;
  - during a mid-run reload, stays high continuously.
- FIFO: first-word-fall-through; pop at edge P presents the next entry from P+1.
- Reset mid-operation: all state returns to reset values immediately; in-flight and queued nonces are lost.

## Test plan
Bench hasher model: delay line of LATENCY = 8 that returns 0 for chosen nonces and nonzero otherwise.

- **Basic scan:** load nonce 0x00001000, count 16, stride 1, zero at 0x00001005 → exactly one golden 0x00001005, valid 9 cycles after that nonce was issued; `tx_busy` high for 24 cycles.
- **Wrap:** load 0xFFFFFFFE, count 4, zero at 0x00000000 → `tx_data` word 3 sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; golden 0x00000000.
- **Stride:** stride 4, load 0x00000002, count 8, zero at 0x0000000E → issued 2, 6, …, 0x1E; golden 0x0000000E only.
- **Abort:** load job A (zero at its 10th nonce), reload job B 3 cycles before A's hit returns → no A golden; B scans from its base; `tx_busy` never drops.
- **FIFO overflow:** `rx_golden_ready` = 0, count 8, five zero hashes → 4 entries retained in issue order, `tx_overflow` = 1. Then hold ready = 1 → 4 pops, valid drops.
- **Reset mid-run:** assert `reset_n` = 0 mid-RUN with one golden queued → all outputs 0 asynchronously; no golden after release.

Source files
------------

// File: rtl/sha256_nonce_dispatcher.sv
// Nonce dispatcher for an unrolled SHA-256 core: issues one padded block per clock,
// tracks in-flight nonces through a fixed-latency valid pipe and queues golden nonces.
module sha256_nonce_dispatcher #(
    parameter int          LATENCY      = 8,
    parameter logic [31:0] NONCE_STRIDE = 32'd1,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rx_work_valid,
    input  logic [255:0] rx_work_midstate,
    input  logic [95:0]  rx_work_data,
    input  logic [31:0]  rx_work_nonce,
    input  logic [31:0]  rx_work_count,
    output logic [255:0] tx_state,
    output logic [511:0] tx_data,
    input  logic [31:0]  rx_hash,
    output logic         tx_golden_valid,
    output logic [31:0]  tx_golden_nonce,
    input  logic         rx_golden_ready,
    output logic         tx_busy,
    output logic         tx_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [255:0]       midstate_q, midstate_d;
    logic [95:0]        data_q, data_d;
    logic [31:0]        nonce_q, nonce_d;
    logic [31:0]        check_q, check_d;
    logic [31:0]        remaining_q, remaining_d;
    logic               loaded_q, loaded_d;
    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [31:0]        fifo_mem_q [FIFO_DEPTH];
    logic [31:0]        fifo_mem_d [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;

    logic check_hit, fifo_full, fifo_empty, push, pop;

    always_comb begin
        state_d     = state_q;
        midstate_d  = midstate_q;
        data_d      = data_q;
        nonce_d     = nonce_q;
        check_d     = check_q;
        remaining_d = remaining_q;
        loaded_d    = loaded_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        fifo_mem_d  = fifo_mem_q;

        vld_pipe_d = (vld_pipe_q << 1) | LATENCY'(state_q == S_RUN);
        check_hit  = vld_pipe_q[LATENCY-1];
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
        pop        = !fifo_empty && rx_golden_ready;
        // A reload discards whatever the hasher returns in the same cycle.
        push       = check_hit && (rx_hash == 32'd0) && !rx_work_valid;

        if (check_hit)
            check_d = check_q + NONCE_STRIDE;

        case (state_q)
            S_RUN: begin
                remaining_d = remaining_q - 32'd1;
                // Count of 0 wraps through 2^32 issues before reaching 1.
                if (remaining_q == 32'd1)
                    state_d = S_DRAIN;
                else
                    nonce_d = nonce_q + NONCE_STRIDE;
            end
            S_DRAIN: begin
                if (vld_pipe_d == '0)
                    state_d = S_IDLE;
            end
            default: ;
        endcase

        if (rx_work_valid) begin
            state_d     = S_RUN;
            midstate_d  = rx_work_midstate;
            data_d      = rx_work_data;
            nonce_d     = rx_work_nonce;
            check_d     = rx_work_nonce;
            remaining_d = rx_work_count;
            loaded_d    = 1'b1;
            vld_pipe_d  = '0;
        end

        if (pop)
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (push) begin
            if (!fifo_full || pop) begin
                fifo_mem_d[wr_ptr_q[AW-1:0]] = check_q;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            midstate_q  <= '0;
            data_q      <= '0;
            nonce_q     <= '0;
            check_q     <= '0;
            remaining_q <= '0;
            loaded_q    <= 1'b0;
            vld_pipe_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            midstate_q  <= midstate_d;
            data_q      <= data_d;
            nonce_q     <= nonce_d;
            check_q     <= check_d;
            remaining_q <= remaining_d;
            loaded_q    <= loaded_d;
            vld_pipe_q  <= vld_pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            fifo_mem_q  <= fifo_mem_d;
        end
    end

    // Padding constants stay zero until the first job so reset shows an all-zero block.
    assign tx_data = loaded_q ? {32'h0000_0280, 320'd0, 32'h8000_0000, nonce_q, data_q} : 512'd0;
    assign tx_state        = midstate_q;
    assign tx_golden_valid = (wr_ptr_q != rd_ptr_q);
    assign tx_golden_nonce = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign tx_busy         = (state_q != S_IDLE);
    assign tx_overflow     = overflow_q;

endmodule

// File: tb/tb_sha256_nonce_dispatcher.sv
// Directed bench: two dispatchers (stride 1 and stride 4) fed by a delay-line hasher model.
module tb_sha256_nonce_dispatcher;
    logic         clk, reset_n;
    logic         rx_work_valid;
    logic [255:0] rx_work_midstate;
    logic [95:0]  rx_work_data;
    logic [31:0]  rx_work_nonce, rx_work_count;
    logic         rx_golden_ready;

    logic [255:0] tx_state1, tx_state4;
    logic [511:0] tx_data1, tx_data4;
    logic [31:0]  rx_hash1, rx_hash4, gn1, gn4;
    logic         gv1, gv4, busy1, busy4, ovf1, ovf4;

    logic [31:0] dl1 [8];
    logic [31:0] dl4 [8];
    logic [31:0] gold [5];
    int          ngold;
    int          ncmp, nfail;

    sha256_nonce_dispatcher #(.LATENCY(8), .NONCE_STRIDE(32'd1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .rx_work_valid(rx_work_valid),
        .rx_work_midstate(rx_work_midstate), .rx_work_data(rx_work_data),
        .rx_work_nonce(rx_work_nonce), .rx_work_count(rx_work_count),
        .tx_state(tx_state1), .tx_data(tx_data1), .rx_hash(rx_hash1),
        .tx_golden_valid(gv1), .tx_golden_nonce(gn1), .rx_golden_ready(rx_golden_ready),
        .tx_busy(busy1), .tx_overflow(ovf1));

    sha256_nonce_dispatcher #(.LATENCY(8), .NONCE_STRIDE(32'd4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .rx_work_valid(rx_work_valid),
        .rx_work_midstate(rx_work_midstate), .rx_work_data(rx_work_data),
        .rx_work_nonce(rx_work_nonce), .rx_work_count(rx_work_count),
        .tx_state(tx_state4), .tx_data(tx_data4), .rx_hash(rx_hash4),
        .tx_golden_valid(gv4), .tx_golden_nonce(gn4), .rx_golden_ready(rx_golden_ready),
        .tx_busy(busy4), .tx_overflow(ovf4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 7; i > 0; i--) begin
            dl1[i] <= dl1[i-1];
            dl4[i] <= dl4[i-1];
        end
        dl1[0] <= tx_data1[127:96];
        dl4[0] <= tx_data4[127:96];
    end

    function automatic logic [31:0] hashf(input logic [31:0] n);
        hashf = 32'hA5A5_0001;
        for (int i = 0; i < 5; i++)
            if (i < ngold && n === gold[i]) hashf = 32'd0;
    endfunction

    always_comb rx_hash1 = hashf(dl1[7]);
    always_comb rx_hash4 = hashf(dl4[7]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] n, input logic [31:0] c);
        rx_work_valid = 1'b1;
        rx_work_nonce = n;
        rx_work_count = c;
        @(negedge clk);
        rx_work_valid = 1'b0;
    endtask

    task automatic pop_one();
        rx_golden_ready = 1'b1;
        @(negedge clk);
        rx_golden_ready = 1'b0;
    endtask

    task automatic wait_gv(input bit s4, output logic [31:0] n, output bit found);
        found = 1'b0;
        n = 32'hxxxx_xxxx;
        for (int i = 0; i < 40 && !found; i++) begin
            if (s4 ? gv4 : gv1) begin
                found = 1'b1;
                n = s4 ? gn4 : gn1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, first, drop, gcnt;
        logic [31:0] gn, e;
        logic [31:0] exp_q [4];
        bit found;

        ncmp = 0; nfail = 0; ngold = 0;
        for (int i = 0; i < 5; i++) gold[i] = 32'd0;
        reset_n = 1'b0;
        rx_work_valid = 1'b0;
        rx_work_midstate = 256'h0123_4567_89AB_CDEF_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
        rx_work_data = 96'hAAAA_0000_BBBB_1111_CCCC_2222;
        rx_work_nonce = 32'd0;
        rx_work_count = 32'd0;
        rx_golden_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_busy",  32'(busy1), 32'd0);
        chk("rst_gv",    32'(gv1),   32'd0);
        chk("rst_gn",    gn1,        32'd0);
        chk("rst_ovf",   32'(ovf1),  32'd0);
        chk("rst_w3",    tx_data1[127:96], 32'd0);
        chk("rst_w15",   tx_data1[511:480], 32'd0);
        chk("rst_state", tx_state1[31:0], 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic scan
        gold[0] = 32'h0000_1005; ngold = 1;
        load(32'h0000_1000, 32'd16);
        chk("basic_w0",    tx_data1[31:0],    32'hCCCC_2222);
        chk("basic_w2",    tx_data1[95:64],   32'hAAAA_0000);
        chk("basic_w4",    tx_data1[159:128], 32'h8000_0000);
        chk("basic_w5",    tx_data1[191:160], 32'd0);
        chk("basic_w15",   tx_data1[511:480], 32'h0000_0280);
        chk("basic_state", tx_state1[255:224], 32'h0123_4567);
        busy_cnt = 0; first = 0; gn = 32'd0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (busy1) busy_cnt++;
            if (cyc == 1 || cyc == 6)
                chk("basic_w3", tx_data1[127:96], 32'h0000_1000 + 32'(cyc - 1));
            if (gv1 && first == 0) begin first = cyc; gn = gn1; end
            @(negedge clk);
        end
        chk("basic_busy_cycles", 32'(busy_cnt), 32'd24);
        chk("basic_gv_cycle",    32'(first),    32'd15);
        chk("basic_golden",      gn,            32'h0000_1005);
        chk("basic_w3_hold",     tx_data1[127:96], 32'h0000_100F);
        chk("basic_ovf",         32'(ovf1),     32'd0);
        pop_one();
        chk("basic_gv_empty",    32'(gv1),      32'd0);

        // Wrap
        gold[0] = 32'h0000_0000;
        load(32'hFFFF_FFFE, 32'd4);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            e = 32'hFFFF_FFFE + 32'(cyc - 1);
            chk("wrap_w3", tx_data1[127:96], e);
            @(negedge clk);
        end
        wait_gv(1'b0, gn, found);
        chk("wrap_found",  32'(found), 32'd1);
        chk("wrap_golden", gn, 32'h0000_0000);
        pop_one();

        // Abort and restart
        gold[0] = 32'h0000_2009; gold[1] = 32'h0000_3001; ngold = 2;
        drop = 0; first = 0; gn = 32'd0;
        load(32'h0000_2000, 32'd16);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (!busy1) drop++;
            @(negedge clk);
        end
        load(32'h0000_3000, 32'd4);
        chk("abort_w3", tx_data1[127:96], 32'h0000_3000);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc <= 12 && !busy1) drop++;
            if (gv1 && first == 0) begin first = cyc; gn = gn1; end
            @(negedge clk);
        end
        chk("abort_busy_drop", 32'(drop),  32'd0);
        chk("abort_gv_cycle",  32'(first), 32'd11);
        chk("abort_golden",    gn,         32'h0000_3001);
        chk("abort_idle",      32'(busy1), 32'd0);
        pop_one();
        chk("abort_gv_empty",  32'(gv1),   32'd0);

        // FIFO overflow
        gold[0] = 32'h0000_4000; gold[1] = 32'h0000_4001; gold[2] = 32'h0000_4003;
        gold[3] = 32'h0000_4005; gold[4] = 32'h0000_4007; ngold = 5;
        exp_q[0] = 32'h0000_4000; exp_q[1] = 32'h0000_4001;
        exp_q[2] = 32'h0000_4003; exp_q[3] = 32'h0000_4005;
        load(32'h0000_4000, 32'd8);
        repeat (20) @(negedge clk);
        chk("ovf_flag", 32'(ovf1), 32'd1);
        rx_golden_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_gv",   32'(gv1), 32'd1);
            chk("ovf_head", gn1, exp_q[i]);
            @(negedge clk);
        end
        rx_golden_ready = 1'b0;
        chk("ovf_drained", 32'(gv1),  32'd0);
        chk("ovf_sticky",  32'(ovf1), 32'd1);

        // Reset mid-run
        gold[0] = 32'h0000_5002; ngold = 1;
        load(32'h0000_5000, 32'd20);
        repeat (13) @(negedge clk);
        chk("rstrun_queued", 32'(gv1), 32'd1);
        reset_n = 1'b0;
        #2;
        chk("rstrun_busy",  32'(busy1), 32'd0);
        chk("rstrun_gv",    32'(gv1),   32'd0);
        chk("rstrun_gn",    gn1,        32'd0);
        chk("rstrun_ovf",   32'(ovf1),  32'd0);
        chk("rstrun_w3",    tx_data1[127:96], 32'd0);
        chk("rstrun_state", tx_state1[31:0],  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        gcnt = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (gv1) gcnt++;
            @(negedge clk);
        end
        chk("rstrun_no_golden", 32'(gcnt),  32'd0);
        chk("rstrun_idle",      32'(busy1), 32'd0);

        // Stride 4
        gold[0] = 32'h0000_000E; ngold = 1;
        load(32'h0000_0002, 32'd8);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            chk("stride_w3", tx_data4[127:96], 32'h0000_0002 + 32'(4 * (cyc - 1)));
            @(negedge clk);
        end
        wait_gv(1'b1, gn, found);
        chk("stride_found",  32'(found), 32'd1);
        chk("stride_golden", gn, 32'h0000_000E);
        pop_one();
        repeat (15) @(negedge clk);
        chk("stride_only_one", 32'(gv4),   32'd0);
        chk("stride_idle",     32'(busy4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
